mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Byte-serial memory arbiter that shares the single 8-bit RAM port between the instruction-fetch stage and the load/store (MEM) stage. It accepts 32-bit-addressed byte, halfword and word requests and sequences them into one-byte-per-cycle RAM accesses. For reads it reassembles the bytes little-endian into a 32-bit result; for writes it splits the store data into bytes. It sits between the pipeline's IF/MEM stages and the top-level RAM interface and is the only driver of that interface.

## Interface
- ADDR_W, 32, width of all addresses and of `ram_a`
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (low = reset)
- if_req  in  1  fetch request, held high until `if_ack`
- if_addr  in  ADDR_W  fetch address (always a 4-byte read)
- if_ack  out  1  one-cycle pulse, `if_data` valid
- if_data  out  32  fetched word
- mem_req  in  1  load/store request, held high until `mem_ack`
- mem_wr  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = half, 2 or 3 = word
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  32  store data; low bytes used first
- mem_ack  out  1  one-cycle pulse; on loads `mem_rdata` is valid
- mem_rdata  out  32  load data, zero-extended
- ram_din  in  8  RAM read data, valid the cycle after `ram_a` is presented
- ram_dout  out  8  RAM write data
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- busy  out  1  high in every non-IDLE state

## Operation
- States: IDLE, READ, WRITE, ACK.
- IDLE:
  - If `mem_req` is high, latch `mem_addr`, `mem_size`, `mem_wr` and `mem_wdata`. Go to WRITE if `mem_wr` = 1, else READ.
  - Otherwise, if `if_req` is high, latch a 4-byte read for the fetch port and go to READ.
  - The data port has fixed priority over fetch.
- Byte count N = 1, 2 or 4, taken from the size (fetch always 4).
- Address k = base + k, modulo 2^ADDR_W (wraps 0xFFFFFFFF to 0x0). No alignment check is made.
- READ:
  - Byte k address is presented on `ram_a` for one cycle, k = 0..N-1, issued back-to-back.
  - `ram_din` is captured one cycle later into bits [8k+7:8k].
  - After the last byte is captured, go to ACK.
- WRITE:
  - Each cycle present address k, `ram_dout` = wdata[8k+7:8k] and `ram_wr` = 1.
  - After byte N-1 is written, go to ACK.
- ACK:
  - Pulse the ack of the granted port for one cycle, with the result on its data bus.
  - Return to IDLE.
  - Requests are not sampled during ACK.
- Data outputs:
  - `if_data` and `mem_rdata` hold their last value until the next ack on that port.
  - Unused upper bytes are 0 for byte and half loads.
  - Sign extension is done downstream, not in this block.
- `ram_wr` is 0 in every state except WRITE. `ram_a` holds its last value when idle.

## Timing
- Reset (`rst` low, asynchronous): state = IDLE and every output = 0. This includes `ram_a`, `ram_dout`, `ram_wr`, both acks, both data buses and `busy`.
- Reset mid-operation: abort immediately with no ack. Bytes already written stay in RAM. After reset deassertion the requester must re-issue.
- E0 = the rising edge at which IDLE samples the request.
- Read of N bytes:
  - Byte k address is visible in the cycle after E0+k.
  - The ack cycle follows edge E0+N+1; word reads ack in the cycle after E0+5.
- Write of N bytes:
  - `ram_wr` is high in cycles E0+0 .. E0+N-1 (the cycles after those edges).
  - The ack cycle follows edge E0+N.
- Back-to-back requests:
  - The earliest next grant is the edge ending the ack cycle plus one: IDLE must see the request.
  - A requester that keeps its req high after its ack is treated as a new request.
- Simultaneous `if_req` and `mem_req`: mem is granted. Fetch is granted at the first IDLE with `mem_req` low.
- Requester inputs may change after E0; the latched copy is used.

## Test plan
- Reset: hold `rst` low mid-transfer → all outputs 0 in the same cycle. After release, `busy` = 0 and no ack occurs.
- Fetch at 0x100, RAM bytes 0x13, 0x05, 0x10, 0x00 → `ram_a` = 0x100..0x103 on consecutive cycles. `if_ack` 5 cycles after grant with `if_data` = 0x00100513.
- SB 0x...AB at 0x2003 → one cycle with `ram_wr` = 1, `ram_a` = 0x2003, `ram_dout` = 0xAB. `mem_ack` the next cycle.
- SW 0xDEADBEEF at 0x40 → writes EF, BE, AD, DE to 0x40..0x43. A following LW at 0x40 returns 0xDEADBEEF.
- `if_req` and `mem_req` (LH at 0xFFFFFFFF, bytes 0x34, 0x12) both raised at the same edge:
  - mem is served first: addresses 0xFFFFFFFF then 0x0, `mem_rdata` = 0x00001234.
  - fetch is granted only after the `mem_ack` cycle and a following IDLE.
- Reset asserted after 2 bytes of an SW → `ram_wr` drops immediately. No `mem_ack`; only 2 bytes modified.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM port between instruction fetch and load/store.
// Multi-byte requests become one RAM byte per cycle; read bytes are reassembled little-endian.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [2:0]        n_r;
  logic [2:0]        cnt_r;
  logic [31:0]       wdata_r;
  logic [31:0]       buf_r;
  logic              fetch_r;

  logic [2:0]        nxt_s;
  logic [2:0]        prv_s;
  logic [31:0]       cap_s;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [2:0] k);
    return 8'(w >> {k, 3'b000});
  endfunction

  // The assembly buffer is cleared at grant, so OR-ing a lane in is enough.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] k,
                                           input logic [7:0] b);
    return w | (32'(b) << {k, 3'b000});
  endfunction

  assign nxt_s = cnt_r + 3'd1;
  assign prv_s = cnt_r - 3'd1;
  assign cap_s = put_byte(buf_r, prv_s, ram_din);

  // Arbitration FSM with all interface outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      base_r    <= '0;
      n_r       <= 3'd0;
      cnt_r     <= 3'd0;
      wdata_r   <= 32'd0;
      buf_r     <= 32'd0;
      fetch_r   <= 1'b0;
      if_ack    <= 1'b0;
      if_data   <= 32'd0;
      mem_ack   <= 1'b0;
      mem_rdata <= 32'd0;
      ram_dout  <= 8'd0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          cnt_r   <= 3'd0;
          buf_r   <= 32'd0;
          if (mem_req) begin
            base_r  <= mem_addr;
            n_r     <= size_bytes(mem_size);
            wdata_r <= mem_wdata;
            fetch_r <= 1'b0;
            ram_a   <= mem_addr;
            busy    <= 1'b1;
            if (mem_wr) begin
              ram_dout <= mem_wdata[7:0];
              ram_wr   <= 1'b1;
              state_r  <= WRITE;
            end else begin
              state_r  <= READ;
            end
          end else if (if_req) begin
            base_r  <= if_addr;
            n_r     <= 3'd4;
            fetch_r <= 1'b1;
            ram_a   <= if_addr;
            busy    <= 1'b1;
            state_r <= READ;
          end else begin
            busy    <= 1'b0;
          end
        end
        READ: begin
          // Byte k arrives on ram_din two edges after its address was registered.
          cnt_r <= nxt_s;
          if (cnt_r != 3'd0) begin
            buf_r <= cap_s;
          end
          if (cnt_r == n_r) begin
            state_r <= ACK;
            if (fetch_r) begin
              if_ack  <= 1'b1;
              if_data <= cap_s;
            end else begin
              mem_ack   <= 1'b1;
              mem_rdata <= cap_s;
            end
          end else if (nxt_s < n_r) begin
            ram_a <= base_r + ADDR_W'(nxt_s);
          end
        end
        WRITE: begin
          if (nxt_s < n_r) begin
            cnt_r    <= nxt_s;
            ram_a    <= base_r + ADDR_W'(nxt_s);
            ram_dout <= lane(wdata_r, nxt_s);
          end else begin
            ram_wr  <= 1'b0;
            mem_ack <= 1'b1;
            state_r <= ACK;
          end
        end
        ACK: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          ram_wr  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM responder, transaction-level expected-cycle model,
// per-cycle comparison, directed literal checks and randomized request traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        busy;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM contents (environment) and the model's own view of memory
  logic [7:0] ram [logic [31:0]];
  logic [7:0] mm  [logic [31:0]];

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_mm(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    mm[a]  = b;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // RAM: data for the address presented in a cycle appears in the next cycle
  always @(posedge clk) begin
    logic [7:0] t;
    t = rd_ram(ram_a);
    if (ram_wr) ram[ram_a] = ram_dout;
    ram_din <= t;
  end

  // Expected outputs of every busy cycle of a granted transaction
  typedef struct {
    logic [31:0] a;
    logic [7:0]  dout;
    logic        wr;
    logic        if_ack;
    logic        mem_ack;
    logic [31:0] if_data;
    logic [31:0] mem_rdata;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] h_a = 32'd0, h_ifd = 32'd0, h_memd = 32'd0;
  logic [7:0]  h_dout = 8'd0;

  task automatic grant(input bit is_mem, input bit wr, input logic [1:0] size,
                       input logic [31:0] base, input logic [31:0] wdata);
    int n;
    cyc_t r;
    logic [31:0] data;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    r.if_ack = 1'b0; r.mem_ack = 1'b0; r.if_data = h_ifd; r.mem_rdata = h_memd;
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        r.a = base + 32'(k); r.dout = 8'(wdata >> (8 * k)); r.wr = 1'b1;
        q.push_back(r);
      end
      r.wr = 1'b0; r.mem_ack = 1'b1;
      q.push_back(r);
      h_a = r.a; h_dout = r.dout;
    end else begin
      data = 32'd0;
      for (int k = 0; k < n; k++) data = data + (32'(rd_mm(base + 32'(k))) << (8 * k));
      r.wr = 1'b0; r.dout = h_dout;
      for (int k = 0; k <= n; k++) begin
        r.a = base + 32'((k < n) ? k : n - 1);
        q.push_back(r);
      end
      if (is_mem) begin r.mem_ack = 1'b1; r.mem_rdata = data; h_memd = data; end
      else        begin r.if_ack  = 1'b1; r.if_data   = data; h_ifd  = data; end
      q.push_back(r);
      h_a = r.a;
    end
  endtask

  // Model: retire the finished cycle, or arbitrate if that cycle was idle
  always @(posedge clk or negedge rst) begin
    cyc_t r;
    if (!rst) begin
      q.delete();
      h_a = 32'd0; h_dout = 8'd0; h_ifd = 32'd0; h_memd = 32'd0;
    end else if (q.size() > 0) begin
      r = q.pop_front();
      if (r.wr) mm[r.a] = r.dout;
    end else if (mem_req) begin
      grant(1'b1, mem_wr, mem_size, mem_addr, mem_wdata);
    end else if (if_req) begin
      grant(1'b0, 1'b0, 2'd2, if_addr, 32'd0);
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [107:0] e, g;
    if (!rst)            e = '0;
    else if (q.size() > 0)
      e = {q[0].a, q[0].dout, q[0].wr, 1'b1, q[0].if_ack, q[0].mem_ack, q[0].if_data, q[0].mem_rdata};
    else
      e = {h_a, h_dout, 1'b0, 1'b0, 1'b0, 1'b0, h_ifd, h_memd};
    g = {ram_a, ram_dout, ram_wr, busy, if_ack, mem_ack, if_data, mem_rdata};
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL cycle_cmp @%0t got %h expected %h (a,dout,wr,busy,if_ack,mem_ack,if_data,mem_rdata)",
               $time, g, e);
    end
  end

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFFFFFC + 32'($urandom_range(0, 3));
    return 32'h40 + 32'($urandom_range(0, 31));
  endfunction

  task automatic rand_mem();
    mem_req = 1'b1; mem_wr = 1'($urandom_range(0, 1)); mem_size = 2'($urandom_range(0, 3));
    mem_addr = rand_addr(); mem_wdata = $urandom;
  endtask

  task automatic rand_if();
    if_req = 1'b1; if_addr = rand_addr();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int ack_c, iack_c, acks;
    logic [31:0] got, got2, sw;
    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_wr = 1'b0;
    mem_size = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ram_a", ram_a, 32'd0);
    check("reset_ctrl", {27'd0, ram_wr, busy, if_ack, mem_ack, 1'b0}, 32'd0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Fetch at 0x100
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    if_req = 1'b1; if_addr = 32'h100; ack_c = -1; got = 32'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 4) check("fetch_addr", ram_a, 32'h100 + 32'(c));
      if (if_ack && ack_c < 0) begin ack_c = c; got = if_data; if_req = 1'b0; end
    end
    check("fetch_ack_cycle", 32'(ack_c), 32'd5);
    check("fetch_data", got, 32'h00100513);

    // SB at 0x2003; inputs scrambled after grant must not matter
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'd0; mem_addr = 32'h2003; mem_wdata = 32'h123456AB;
    ack_c = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("sb_wr", {31'd0, ram_wr}, 32'd1);
        check("sb_addr", ram_a, 32'h2003);
        check("sb_dout", {24'd0, ram_dout}, 32'h000000AB);
        mem_addr = 32'h5555; mem_wdata = 32'hFFFFFFFF;
      end
      if (mem_ack && ack_c < 0) begin ack_c = c; mem_req = 1'b0; end
    end
    check("sb_ack_cycle", 32'(ack_c), 32'd1);
    check("sb_ram", {24'd0, rd_ram(32'h2003)}, 32'h000000AB);
    check("sb_ram_next", {24'd0, rd_ram(32'h2004)}, 32'h00000000);

    // SW 0xDEADBEEF at 0x40, then LW back
    sw = 32'hDEADBEEF;
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'd2; mem_addr = 32'h40; mem_wdata = sw;
    ack_c = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check("sw_addr", ram_a, 32'h40 + 32'(c));
        check("sw_dout", {24'd0, ram_dout}, {24'd0, sw[8*c +: 8]});
      end
      if (mem_ack && ack_c < 0) begin ack_c = c; mem_req = 1'b0; end
    end
    check("sw_ack_cycle", 32'(ack_c), 32'd4);
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h40;
    ack_c = -1; got = 32'd0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (mem_ack && ack_c < 0) begin ack_c = c; got = mem_rdata; mem_req = 1'b0; end
    end
    check("lw_ack_cycle", 32'(ack_c), 32'd5);
    check("lw_data", got, 32'hDEADBEEF);

    // Simultaneous requests; LH wraps from 0xFFFFFFFF to 0
    poke(32'hFFFFFFFF, 8'h34); poke(32'h0, 8'h12);
    poke(32'h300, 8'hA5); poke(32'h301, 8'h5A); poke(32'h302, 8'hC3); poke(32'h303, 8'h3C);
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd1; mem_addr = 32'hFFFFFFFF;
    ack_c = -1; iack_c = -1; got = 32'd0; got2 = 32'd0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) check("lh_addr0", ram_a, 32'hFFFFFFFF);
      if (c == 1) check("lh_addr1", ram_a, 32'h00000000);
      if (c == 4) check("gap_busy", {31'd0, busy}, 32'd0);
      if (c == 5) check("fetch_after_mem", ram_a, 32'h300);
      if (mem_ack && ack_c < 0)  begin ack_c = c;  got = mem_rdata; mem_req = 1'b0; end
      if (if_ack && iack_c < 0) begin iack_c = c; got2 = if_data; if_req = 1'b0; end
    end
    check("lh_ack_cycle", 32'(ack_c), 32'd3);
    check("lh_data", got, 32'h00001234);
    check("fetch2_ack_cycle", 32'(iack_c), 32'd10);
    check("fetch2_data", got2, 32'h3CC35AA5);

    // Reset during the third byte of an SW
    poke(32'h80, 8'h11); poke(32'h81, 8'h22); poke(32'h82, 8'h33); poke(32'h83, 8'h44);
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'd3; mem_addr = 32'h80; mem_wdata = 32'hA1B2C3D4;
    repeat (3) @(negedge clk);
    check("rst_pre_wr", {31'd0, ram_wr}, 32'd1);
    check("rst_pre_addr", ram_a, 32'h82);
    #2 rst = 1'b0;
    #1;
    check("rst_now_ctrl", {27'd0, ram_wr, busy, if_ack, mem_ack, 1'b0}, 32'd0);
    check("rst_now_addr", ram_a, 32'd0);
    check("rst_now_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_now_ifdata", if_data, 32'd0);
    check("rst_now_memrdata", mem_rdata, 32'd0);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acks += int'(if_ack) + int'(mem_ack);
    end
    check("rst_no_ack", 32'(acks), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bytes", {rd_ram(32'h83), rd_ram(32'h82), rd_ram(32'h81), rd_ram(32'h80)}, 32'h4433C3D4);

    // Random traffic; requesters hold req until ack, sometimes re-request at once
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (mem_req && mem_ack) begin
        if (cyc < 2900 && $urandom_range(0, 3) == 0) rand_mem();
        else mem_req = 1'b0;
      end else if (!mem_req && cyc < 2900 && $urandom_range(0, 2) == 0) begin
        rand_mem();
      end
      if (if_req && if_ack) begin
        if (cyc < 2900 && $urandom_range(0, 3) == 0) rand_if();
        else if_req = 1'b0;
      end else if (!if_req && cyc < 2900 && $urandom_range(0, 2) == 0) begin
        rand_if();
      end
    end
    check("drain_reqs", {30'd0, mem_req, if_req}, 32'd0);
    repeat (10) @(negedge clk);
    foreach (mm[a]) check("mem_final", {24'd0, rd_ram(a)}, {24'd0, mm[a]});
    foreach (ram[a]) check("mem_final_rev", {24'd0, rd_mm(a)}, {24'd0, ram[a]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
